// File: rtl/pwu_pkg.sv
// Shared widths and types for the page-walk unit front end.
package pwu_pkg;
  localparam int VA_W       = 32;
  localparam int PA_W       = 28;
  localparam int INFLIGHT_W = 4;

  typedef logic [VA_W-1:0] va_t;
endpackage

// File: rtl/va_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally from the read pointer.
module va_fifo
  import pwu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = VA_W
) (
  input  logic                         clk_i,
  input  logic                         resetn_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 data_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is reset so the head reads as zero out of reset; only affordable because DEPTH is tiny.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/va_issue_queue.sv
// VA request queue feeding the page-walk unit, metered by an in-flight credit counter.
// Optional same-cycle bypass of an empty queue is enabled with `define VA_ISSUE_BYPASS_EN.
module va_issue_queue
  import pwu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  va_t                        req_va_i,
  input  logic                       req_vld_i,
  output logic                       req_rdy_o,
  output va_t                        va_o,
  output logic                       va_vld_o,
  input  logic                       va_rdy_i,
  input  logic                       pa_vld_i,
  input  logic                       pa_rdy_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [INFLIGHT_W-1:0]      inflight_o,
  output logic                       empty_o,
  output logic                       full_o
);
  logic [INFLIGHT_W-1:0] r_inflight;
  va_t  w_head;
  logic w_empty, w_full, w_credit, w_fifo_vld;
  logic w_push, w_pop, w_done, w_fifo_push, w_fifo_pop;

  assign w_credit   = (r_inflight < INFLIGHT_W'(MAX_INFLIGHT));
  assign w_fifo_vld = ~w_empty & w_credit;
  assign req_rdy_o  = ~w_full;
  assign w_push     = req_vld_i & req_rdy_o;
  assign w_pop      = va_vld_o & va_rdy_i;
  // Completions with nothing outstanding (e.g. for walks issued before a reset) are dropped.
  assign w_done     = pa_vld_i & pa_rdy_i & (r_inflight != '0);

`ifdef VA_ISSUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_empty & ~flush_i & w_credit;
  assign va_vld_o    = w_bypass ? req_vld_i : w_fifo_vld;
  assign va_o        = w_bypass ? req_va_i  : w_head;
  assign w_fifo_push = w_push & ~(w_bypass & va_rdy_i);
  assign w_fifo_pop  = w_pop & ~w_bypass;
`else
  assign va_vld_o    = w_fifo_vld;
  assign va_o        = w_head;
  assign w_fifo_push = w_push;
  assign w_fifo_pop  = w_pop;
`endif

  va_fifo #(.DEPTH(DEPTH), .W(VA_W)) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .push_i   (w_fifo_push),
    .pop_i    (w_fifo_pop),
    .flush_i  (flush_i),
    .data_i   (req_va_i),
    .head_o   (w_head),
    .count_o  (count_o),
    .empty_o  (w_empty),
    .full_o   (w_full)
  );

  // A pop in the flush cycle still reached the walker, so it is counted regardless of flush_i.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_pop, w_done})
        2'b10:   r_inflight <= r_inflight + INFLIGHT_W'(1);
        2'b01:   r_inflight <= r_inflight - INFLIGHT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign inflight_o = r_inflight;
  assign empty_o    = w_empty;
  assign full_o     = w_full;
endmodule
